// File: rtl/soc_pio_in_multi.sv
// Multi-channel synchronised parallel input port (Avalon-MM slave) with per-channel edge
// capture, IRQ mask and one level interrupt. Define SOC_PIO_IN_TIMESTAMP_EN for edge timestamps.
module soc_pio_in_multi #(
  parameter int  WIDTH       = 32,
  parameter int  CHANNELS    = 4,
  parameter int  SYNC_STAGES = 2,
  parameter int  EDGE_TYPE   = 0,
  localparam int ADDR_W      = (CHANNELS == 1) ? 2 : $clog2(CHANNELS) + 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_W-1:0]         address,
  input  logic                      read,
  input  logic                      write,
  input  logic [WIDTH-1:0]          writedata,
  output logic [WIDTH-1:0]          readdata,
  input  logic [CHANNELS*WIDTH-1:0] in_port,
  output logic                      irq
);

  localparam int CH_W = (CHANNELS == 1) ? 1 : ADDR_W - 2;
  localparam int WU_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WU_W-1:0] WU_LOAD = WU_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    REG_DATA      = 2'd0,
    REG_IRQMASK   = 2'd1,
    REG_EDGECAP   = 2'd2,
    REG_TIMESTAMP = 2'd3
  } reg_e;

  logic [WIDTH-1:0] sync_q [CHANNELS][SYNC_STAGES];
  logic [WIDTH-1:0] prev_q [CHANNELS];
  logic [WIDTH-1:0] mask_q [CHANNELS];
  logic [WIDTH-1:0] cap_q  [CHANNELS];
  logic [WIDTH-1:0] cap_d  [CHANNELS];
  logic [WIDTH-1:0] data_w [CHANNELS];
  logic [WIDTH-1:0] edge_w [CHANNELS];
  logic [WU_W-1:0]  warm_q;
  logic             detect_en;
  logic [CH_W-1:0]  ch_sel;
  reg_e             reg_sel;
  logic             ch_valid;
  logic             wr_mask;
  logic             wr_cap;
  logic [WIDTH-1:0] rd_mux;

  // ---------------------------------------------------------------------------
  // Address decode: word address = {channel, reg[1:0]}
  // ---------------------------------------------------------------------------
  assign reg_sel = reg_e'(address[1:0]);

  generate
    if (CHANNELS > 1) begin : g_ch_dec
      assign ch_sel = address[ADDR_W-1:2];
    end else begin : g_ch_one
      assign ch_sel = '0;
    end
  endgenerate

  assign ch_valid  = ({1'b0, ch_sel} < (CH_W + 1)'(CHANNELS));
  assign wr_mask   = write && ch_valid && (reg_sel == REG_IRQMASK);
  assign wr_cap    = write && ch_valid && (reg_sel == REG_EDGECAP);
  assign detect_en = (warm_q == '0);

  // ---------------------------------------------------------------------------
  // Edge detection and next EDGECAP: a new edge overrides a same-cycle W1C.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      data_w[c] = sync_q[c][SYNC_STAGES-1];
      if (!detect_en)          edge_w[c] = '0;
      else if (EDGE_TYPE == 1) edge_w[c] = ~data_w[c] & prev_q[c];
      else if (EDGE_TYPE == 2) edge_w[c] = data_w[c] ^ prev_q[c];
      else                     edge_w[c] = data_w[c] & ~prev_q[c];
      cap_d[c] = cap_q[c];
      if (wr_cap && (ch_sel == CH_W'(c))) cap_d[c] = cap_q[c] & ~writedata;
      cap_d[c] = cap_d[c] | edge_w[c];
    end
  end

  always_comb begin
    irq = 1'b0;
    for (int c = 0; c < CHANNELS; c++) irq = irq | (|(cap_q[c] & mask_q[c]));
  end

`ifdef SOC_PIO_IN_TIMESTAMP_EN
  // Free-running cycle counter; each channel latches it when its EDGECAP leaves all-zero.
  logic [31:0] cycle_q;
  logic [31:0] ts_q [CHANNELS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_q <= '0;
      for (int c = 0; c < CHANNELS; c++) ts_q[c] <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      for (int c = 0; c < CHANNELS; c++)
        if ((cap_q[c] == '0) && (cap_d[c] != '0)) ts_q[c] <= cycle_q;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns rd_mux; otherwise a latch is inferred.
    rd_mux = '0;
    if (ch_valid) begin
      case (reg_sel)
        REG_DATA:      rd_mux = data_w[ch_sel];
        REG_IRQMASK:   rd_mux = mask_q[ch_sel];
        REG_EDGECAP:   rd_mux = cap_q[ch_sel];
        REG_TIMESTAMP: begin
`ifdef SOC_PIO_IN_TIMESTAMP_EN
          rd_mux = ts_q[ch_sel][WIDTH-1:0];
`else
          rd_mux = '0;
`endif
        end
        default:       rd_mux = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      warm_q   <= WU_LOAD;
      readdata <= '0;
      // NOTE: these per-channel arrays are plain flops, not RAM, so resetting every entry is intended.
      for (int c = 0; c < CHANNELS; c++) begin
        prev_q[c] <= '0;
        mask_q[c] <= '0;
        cap_q[c]  <= '0;
        for (int s = 0; s < SYNC_STAGES; s++) sync_q[c][s] <= '0;
      end
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values and the sync chain shifts one stage.
      if (warm_q != '0) warm_q <= warm_q - WU_W'(1);
      for (int c = 0; c < CHANNELS; c++) begin
        sync_q[c][0] <= in_port[c*WIDTH +: WIDTH];
        for (int s = 1; s < SYNC_STAGES; s++) sync_q[c][s] <= sync_q[c][s-1];
        prev_q[c] <= data_w[c];
        cap_q[c]  <= cap_d[c];
        if (wr_mask && (ch_sel == CH_W'(c))) mask_q[c] <= writedata;
      end
      if (read) readdata <= rd_mux;
    end
  end

endmodule
